if_id_skid: RTL and testbench

//   Fetch-to-decode pipeline stage. It registers {pc, inst} from the IF stage and presents

---
 rtl/if_id_skid.sv | 126 ++++++++++++
 tb/tb_if_id_skid.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// Fetch-to-decode pipeline register with a 2-entry skid, so in_ready is driven from state
// and decode back-pressure never reaches fetch combinationally.
module if_id_skid #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_IF,
  input  logic [INST_W-1:0] inst_IF,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_ID,
  output logic [INST_W-1:0] inst_ID,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  logic              mainValid_q, mainValid_d;
  logic              skidValid_q, skidValid_d;
  logic [PC_W-1:0]   mainPc_q, mainPc_d;
  logic [INST_W-1:0] mainInst_q, mainInst_d;
  logic [PC_W-1:0]   skidPc_q, skidPc_d;
  logic [INST_W-1:0] skidInst_q, skidInst_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  state_e            state;
  logic              inFire;
  logic              outFire;

  // Handshake outputs are masked during reset; otherwise they follow the valid registers.
  assign in_ready  = !skidValid_q && !rst;
  assign out_valid = mainValid_q && !rst;
  assign pc_ID     = mainPc_q;
  assign inst_ID   = mainInst_q;
  assign stall_cnt = stallCnt_q;

  assign inFire  = in_valid && in_ready && !flush;
  assign outFire = out_valid && out_ready;

  always_comb begin
    state = EMPTY;
    if (skidValid_q)      state = TWO;
    else if (mainValid_q) state = ONE;
  end

  always_comb begin
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    mainPc_d    = mainPc_q;
    mainInst_d  = mainInst_q;
    skidPc_d    = skidPc_q;
    skidInst_d  = skidInst_q;
    stallCnt_d  = stallCnt_q;

    if (out_valid && !out_ready && (stallCnt_q != {CNT_W{1'b1}}))
      stallCnt_d = stallCnt_q + 1'b1;

    // Flush only drops the valid bits; data registers keep their contents.
    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            mainValid_d = 1'b1;
            mainPc_d    = pc_IF;
            mainInst_d  = inst_IF;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            mainPc_d   = pc_IF;
            mainInst_d = inst_IF;
          end else if (outFire) begin
            mainValid_d = 1'b0;
          end else if (inFire) begin
            skidValid_d = 1'b1;
            skidPc_d    = pc_IF;
            skidInst_d  = inst_IF;
          end
        end
        TWO: begin
          if (outFire) begin
            skidValid_d = 1'b0;
            mainPc_d    = skidPc_q;
            mainInst_d  = skidInst_q;
          end
        end
        default: begin
          mainValid_d = 1'b0;
          skidValid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      mainPc_q    <= '0;
      mainInst_q  <= '0;
      skidPc_q    <= '0;
      skidInst_q  <= '0;
      stallCnt_q  <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      mainPc_q    <= mainPc_d;
      mainInst_q  <= mainInst_d;
      skidPc_q    <= skidPc_d;
      skidInst_q  <= skidInst_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  // A skid entry without a main entry would break FIFO ordering.
  skidNeedsMain: assert property (@(posedge clk) disable iff (rst) !(skidValid_q && !mainValid_q));

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: reset, streaming, back-pressure, flush and counter saturation.
module tb_if_id_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [63:0] pcIf;
  logic [31:0] instIf;

  logic        inReady, outValid;
  logic [63:0] pcId;
  logic [31:0] instId;
  logic [31:0] stallCnt;

  logic        inReady4, outValid4;
  logic [63:0] pcId4;
  logic [31:0] instId4;
  logic [3:0]  stallCnt4;

  int checkCnt = 0;
  int passCnt  = 0;

  if_id_skid #(.PC_W(64), .INST_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .pc_IF(pcIf), .inst_IF(instIf), .out_valid(outValid), .out_ready(outReady),
    .pc_ID(pcId), .inst_ID(instId), .stall_cnt(stallCnt)
  );

  if_id_skid #(.PC_W(64), .INST_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady4),
    .pc_IF(pcIf), .inst_IF(instIf), .out_valid(outValid4), .out_ready(outReady),
    .pc_ID(pcId4), .inst_ID(instId4), .stall_cnt(stallCnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instOf(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1300_0013;
  endfunction

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [63:0] pc, input logic ordy);
    rst      = r;
    flush    = f;
    inValid  = iv;
    pcIf     = pc;
    instIf   = instOf(pc);
    outReady = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkHead(input string tag, input logic [63:0] pc);
    checkOutput({tag, "_valid"}, 64'(outValid), 64'h1);
    checkOutput({tag, "_pc"}, pcId, pc);
    checkOutput({tag, "_inst"}, 64'(instId), 64'(instOf(pc)));
  endtask

  initial begin
    // 1. Reset held two cycles with IF presenting
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h40, 1'b0);
    tick();
    checkOutput("rst1_inReady", 64'(inReady), 64'h0);
    checkOutput("rst1_outValid", 64'(outValid), 64'h0);
    tick();
    checkOutput("rst2_inReady", 64'(inReady), 64'h0);
    checkOutput("rst2_outValid", 64'(outValid), 64'h0);
    checkOutput("rst2_pcId", pcId, 64'h0);
    checkOutput("rst2_instId", 64'(instId), 64'h0);
    checkOutput("rst2_stall", 64'(stallCnt), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    checkOutput("postRst_inReady", 64'(inReady), 64'h1);
    checkOutput("postRst_outValid", 64'(outValid), 64'h0);

    // 2. Streaming at full rate
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0000, 1'b1);
    tick();
    checkHead("stream0", 64'h8000_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0004, 1'b1);
    tick();
    checkHead("stream1", 64'h8000_0004);
    checkOutput("stream1_inReady", 64'(inReady), 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0008, 1'b1);
    tick();
    checkHead("stream2", 64'h8000_0008);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("streamDrain_valid", 64'(outValid), 64'h0);
    checkOutput("streamDrain_pcHold", pcId, 64'h8000_0008);
    checkOutput("stream_stall", 64'(stallCnt), 64'h0);

    // 3. Back-pressure fills main and skid, then drains in order
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h100, 1'b0);
    tick();
    checkHead("bp0", 64'h100);
    checkOutput("bp0_inReady", 64'(inReady), 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h104, 1'b0);
    tick();
    checkOutput("bp1_inReady", 64'(inReady), 64'h0);
    checkHead("bp1", 64'h100);
    checkOutput("bp1_stall", 64'(stallCnt), 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h108, 1'b0);
    tick();
    checkOutput("bp2_inReady", 64'(inReady), 64'h0);
    checkHead("bp2", 64'h100);
    checkOutput("bp2_stall", 64'(stallCnt), 64'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h108, 1'b1);
    tick();
    checkHead("bp3", 64'h104);
    checkOutput("bp3_inReady", 64'(inReady), 64'h1);
    tick();
    checkHead("bp4", 64'h108);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("bp5_valid", 64'(outValid), 64'h0);
    checkOutput("bp5_stall", 64'(stallCnt), 64'h2);

    // 4. Flush while holding two entries
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h200, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h204, 1'b0);
    tick();
    checkOutput("fl2_inReady", 64'(inReady), 64'h0);
    checkHead("fl2", 64'h200);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h208, 1'b0);
    tick();
    checkOutput("flush_valid", 64'(outValid), 64'h0);
    checkOutput("flush_inReady", 64'(inReady), 64'h1);
    checkOutput("flush_pcHold", pcId, 64'h200);
    checkOutput("flush_stall", 64'(stallCnt), 64'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("postFlush_valid", 64'(outValid), 64'h0);
    checkOutput("postFlush_pc", pcId, 64'h200);

    // 5. Flush racing an accept from EMPTY
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h2FC, 1'b1);
    tick();
    checkOutput("race_valid", 64'(outValid), 64'h0);
    checkOutput("race_pc", pcId, 64'h200);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h300, 1'b1);
    tick();
    checkHead("race_next", 64'h300);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("race_drain", 64'(outValid), 64'h0);
    checkOutput("race_stall", 64'(stallCnt), 64'h4);
    checkOutput("race_stall4", 64'(stallCnt4), 64'h4);

    // 6. Stall counter saturation on the 4-bit instance
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("sat_rst", 64'(stallCnt), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h400, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) checkOutput("sat_14", 64'(stallCnt4), 64'hE);
    end
    checkOutput("sat_20_cnt4", 64'(stallCnt4), 64'hF);
    checkOutput("sat_20_cnt32", 64'(stallCnt), 64'd20);
    checkOutput("sat_valid4", 64'(outValid4), 64'h1);
    tick();
    tick();
    checkOutput("sat_hold_cnt4", 64'(stallCnt4), 64'hF);
    checkOutput("sat_hold_cnt32", 64'(stallCnt), 64'd22);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("sat_clr_cnt4", 64'(stallCnt4), 64'h0);
    checkOutput("sat_clr_cnt32", 64'(stallCnt), 64'h0);
    checkOutput("sat_clr_valid", 64'(outValid4), 64'h0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
